// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue queue between fetcher and decoder; optional stall counter under ISSUE_STAT_EN
module issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_valid,
  input  logic [31:0] in_fetcher_inst,
  input  logic [31:0] in_fetcher_pc,
  input  logic        in_fetcher_jump_flag,
  output logic        out_fetcher_ready,
  input  logic        in_rob_full,
  input  logic        in_rs_full,
  input  logic        in_lsb_full,
  input  logic        in_clear,
  output logic        out_dec_valid,
  output logic [31:0] out_dec_inst,
  output logic [31:0] out_dec_pc,
  output logic        out_dec_jump_flag,
  output logic        out_issue
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0] out_stall_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  state_e        state_q, state_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [64:0]   mem_q [DEPTH];

  logic [64:0]   head_entry;
  logic          head_is_ls;
  logic          enq;

  assign head_entry = mem_q[head_q];
  assign head_is_ls = (head_entry[6:0] == 7'b0000011) || (head_entry[6:0] == 7'b0100011);

  // Next-state and output logic; a clear wins over enqueue and issue
  always_comb begin
    state_d           = state_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    out_dec_valid     = (count_q != '0);
    out_dec_inst      = 32'd0;
    out_dec_pc        = 32'd0;
    out_dec_jump_flag = 1'b0;
    out_fetcher_ready = 1'b0;
    out_issue         = 1'b0;
    enq               = 1'b0;

    if (out_dec_valid) begin
      out_dec_inst      = head_entry[31:0];
      out_dec_pc        = head_entry[63:32];
      out_dec_jump_flag = head_entry[64];
    end

    // rst is folded in so the reset cycle never advertises space or issues
    out_fetcher_ready = rst && (state_q == RUN) && (count_q != DEPTH_C) && !in_clear;
    out_issue = rst && rdy && (state_q == RUN) && !in_clear && out_dec_valid && !in_rob_full &&
                (head_is_ls ? !in_lsb_full : !in_rs_full);
    enq = rdy && in_fetcher_valid && out_fetcher_ready;

    if (rdy) begin
      if (in_clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = FLUSH;
      end else begin
        case (state_q)
          RUN:     state_d = RUN;
          default: state_d = RUN;
        endcase
        if (enq) tail_d = tail_q + AW'(1);
        if (out_issue) head_d = head_q + AW'(1);
        count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, out_issue};
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= {in_fetcher_jump_flag, in_fetcher_pc, in_fetcher_inst};
    end
  end

`ifdef ISSUE_STAT_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall         = rdy && out_dec_valid && (state_q == RUN) && !in_clear && !out_issue;
  assign out_stall_cnt = stall_cnt_q;

  // Saturating count of cycles where a presented head could not issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_fetcher_valid;
  logic [31:0] in_fetcher_inst, in_fetcher_pc;
  logic        in_fetcher_jump_flag;
  logic        out_fetcher_ready;
  logic        in_rob_full, in_rs_full, in_lsb_full, in_clear;
  logic        out_dec_valid;
  logic [31:0] out_dec_inst, out_dec_pc;
  logic        out_dec_jump_flag;
  logic        out_issue;
`ifdef ISSUE_STAT_EN
  logic [31:0] out_stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_2003;

  issue_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .in_fetcher_valid    (in_fetcher_valid),
    .in_fetcher_inst     (in_fetcher_inst),
    .in_fetcher_pc       (in_fetcher_pc),
    .in_fetcher_jump_flag(in_fetcher_jump_flag),
    .out_fetcher_ready   (out_fetcher_ready),
    .in_rob_full         (in_rob_full),
    .in_rs_full          (in_rs_full),
    .in_lsb_full         (in_lsb_full),
    .in_clear            (in_clear),
    .out_dec_valid       (out_dec_valid),
    .out_dec_inst        (out_dec_inst),
    .out_dec_pc          (out_dec_pc),
    .out_dec_jump_flag   (out_dec_jump_flag),
    .out_issue           (out_issue)
`ifdef ISSUE_STAT_EN
    ,
    .out_stall_cnt       (out_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; in_fetcher_valid = 1'b0; in_fetcher_inst = '0; in_fetcher_pc = '0;
    in_fetcher_jump_flag = 1'b0; in_rob_full = 1'b0; in_rs_full = 1'b0; in_lsb_full = 1'b0;
    in_clear = 1'b0;

    // reset
    settle();
    chk("rst_ready_pre", {31'd0, out_fetcher_ready}, 32'd0);
    tick();
    chk("rst_valid", {31'd0, out_dec_valid}, 32'd0);
    chk("rst_issue", {31'd0, out_issue}, 32'd0);
    chk("rst_pc", out_dec_pc, 32'd0);
    chk("rst_inst", out_dec_inst, 32'd0);
    chk("rst_ready", {31'd0, out_fetcher_ready}, 32'd0);
    rst = 1'b1;
    settle();
    chk("post_rst_ready", {31'd0, out_fetcher_ready}, 32'd1);

    // 1: single ADDI, issues one cycle after enqueue
    in_fetcher_valid = 1'b1; in_fetcher_inst = ADDI; in_fetcher_pc = 32'h0; in_fetcher_jump_flag = 1'b1;
    settle();
    chk("t1_no_bypass", {31'd0, out_issue}, 32'd0);
    tick();
    in_fetcher_valid = 1'b0; in_fetcher_jump_flag = 1'b0;
    settle();
    chk("t1_valid", {31'd0, out_dec_valid}, 32'd1);
    chk("t1_issue", {31'd0, out_issue}, 32'd1);
    chk("t1_pc", out_dec_pc, 32'h0);
    chk("t1_inst", out_dec_inst, ADDI);
    chk("t1_jump", {31'd0, out_dec_jump_flag}, 32'd1);
    tick();
    chk("t1_empty", {31'd0, out_dec_valid}, 32'd0);

    // 2: fill 8 with RS full, then drain in order
    in_rs_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_fetcher_valid = 1'b1; in_fetcher_inst = ADDI; in_fetcher_pc = 32'h100 + 32'(4 * i);
      settle();
      chk("t2_ready_fill", {31'd0, out_fetcher_ready}, 32'd1);
      tick();
    end
    in_fetcher_pc = 32'h1FC;
    settle();
    chk("t2_full_ready", {31'd0, out_fetcher_ready}, 32'd0);
    chk("t2_stalled", {31'd0, out_issue}, 32'd0);
    tick();
    in_fetcher_valid = 1'b0;
    in_rs_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_drain_issue", {31'd0, out_issue}, 32'd1);
      chk("t2_drain_pc", out_dec_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    chk("t2_empty", {31'd0, out_dec_valid}, 32'd0);

    // 3: LW head blocked by LSB, ADDI behind it waits
    in_lsb_full = 1'b1;
    in_fetcher_valid = 1'b1; in_fetcher_inst = LW; in_fetcher_pc = 32'h200;
    tick();
    in_fetcher_inst = ADDI; in_fetcher_pc = 32'h204;
    tick();
    in_fetcher_valid = 1'b0;
    settle();
    chk("t3_head_lw", out_dec_inst, LW);
    chk("t3_blocked_a", {31'd0, out_issue}, 32'd0);
    tick();
    chk("t3_blocked_b", {31'd0, out_issue}, 32'd0);
    in_lsb_full = 1'b0;
    settle();
    chk("t3_lw_issue", {31'd0, out_issue}, 32'd1);
    chk("t3_lw_pc", out_dec_pc, 32'h200);
    tick();
    chk("t3_addi_issue", {31'd0, out_issue}, 32'd1);
    chk("t3_addi_pc", out_dec_pc, 32'h204);
    tick();
    chk("t3_empty", {31'd0, out_dec_valid}, 32'd0);

    // 4: clear with 5 queued, head issuable
    in_rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_fetcher_valid = 1'b1; in_fetcher_inst = ADDI; in_fetcher_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    in_fetcher_valid = 1'b0;
    in_rs_full = 1'b0;
    in_clear = 1'b1;
    settle();
    chk("t4_clear_issue", {31'd0, out_issue}, 32'd0);
    chk("t4_clear_ready", {31'd0, out_fetcher_ready}, 32'd0);
    tick();
    in_clear = 1'b0;
    in_fetcher_valid = 1'b1; in_fetcher_pc = 32'h4FC;
    settle();
    chk("t4_flush_empty", {31'd0, out_dec_valid}, 32'd0);
    chk("t4_flush_ready", {31'd0, out_fetcher_ready}, 32'd0);
    tick();
    in_fetcher_valid = 1'b0;
    chk("t4_flush_no_enq", {31'd0, out_dec_valid}, 32'd0);
    chk("t4_run_ready", {31'd0, out_fetcher_ready}, 32'd1);

    // 5: streaming 20 instructions, pointers wrap
    for (int i = 0; i < 20; i++) begin
      in_fetcher_valid = 1'b1; in_fetcher_inst = ADDI; in_fetcher_pc = 32'h300 + 32'(4 * i);
      settle();
      if (i == 0) begin
        chk("t5_first", {31'd0, out_issue}, 32'd0);
      end else begin
        chk("t5_issue", {31'd0, out_issue}, 32'd1);
        chk("t5_pc", out_dec_pc, 32'h300 + 32'(4 * (i - 1)));
        chk("t5_ready", {31'd0, out_fetcher_ready}, 32'd1);
      end
      tick();
    end
    in_fetcher_valid = 1'b0;
    settle();
    chk("t5_last_issue", {31'd0, out_issue}, 32'd1);
    chk("t5_last_pc", out_dec_pc, 32'h34C);
    tick();
    chk("t5_empty", {31'd0, out_dec_valid}, 32'd0);

    // rdy=0 freezes state and suppresses issue
    in_fetcher_valid = 1'b1; in_fetcher_pc = 32'h500;
    tick();
    in_fetcher_valid = 1'b0;
    rdy = 1'b0;
    in_clear = 1'b1;
    settle();
    chk("frz_issue", {31'd0, out_issue}, 32'd0);
    tick();
    in_clear = 1'b0;
    chk("frz_hold_valid", {31'd0, out_dec_valid}, 32'd1);
    chk("frz_hold_pc", out_dec_pc, 32'h500);
    rdy = 1'b1;
    settle();
    chk("frz_resume_issue", {31'd0, out_issue}, 32'd1);
    tick();

    // mid-operation reset drops contents
    in_rs_full = 1'b1;
    in_fetcher_valid = 1'b1; in_fetcher_pc = 32'h600;
    tick();
    tick();
    in_fetcher_valid = 1'b0;
    chk("mid_rst_pre", {31'd0, out_dec_valid}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    in_rs_full = 1'b0;
    settle();
    chk("mid_rst_empty", {31'd0, out_dec_valid}, 32'd0);

`ifdef ISSUE_STAT_EN
    // 6: three ROB stalls then a frozen cycle
    chk("t6_cnt_reset", out_stall_cnt, 32'd0);
    in_fetcher_valid = 1'b1; in_fetcher_pc = 32'h700;
    in_rob_full = 1'b1;
    tick();
    in_fetcher_valid = 1'b0;
    chk("t6_cnt_enq", out_stall_cnt, 32'd0);
    tick();
    tick();
    tick();
    chk("t6_cnt_3", out_stall_cnt, 32'd3);
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    chk("t6_cnt_frozen", out_stall_cnt, 32'd3);
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
    in_rob_full = 1'b0;
    chk("t6_cnt_clear_keep", out_stall_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
